// File: rtl/setup_menu.sv
// Configuration-menu controller for the electronic lock: authenticates the master password,
// walks the keypad user through every setting on a shadow copy and commits it atomically.
module setup_menu #(
  parameter int N_USERS        = 4,
  parameter int MAX_DIGITS     = 20,
  parameter int MIN_PWD_DIGITS = 4,
  parameter int T_MIN          = 5,
  parameter int T_MAX          = 60,
  parameter int MAX_AUTH_TRIES = 3,
  parameter int TIMEOUT_CYC    = 100
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            setup_on,
  input  logic [4*MAX_DIGITS-1:0]         digits_value,
  input  logic                            digits_valid,
  output logic                            display_en,
  output logic [23:0]                     bcd,
  output logic                            cfg_bip_status,
  output logic [6:0]                      cfg_bip_time,
  output logic [6:0]                      cfg_trc_time,
  output logic [4*MAX_DIGITS-1:0]         cfg_senha_master,
  output logic [N_USERS*4*MAX_DIGITS-1:0] cfg_senha_user,
  output logic                            cfg_ok,
  output logic                            cfg_abort
);

  localparam int PW = 4 * MAX_DIGITS;
  localparam int UW = N_USERS * PW;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int FW = $clog2(MAX_AUTH_TRIES + 1);
  localparam int IW = 3;
  localparam logic [PW-1:0] MASTER_RST = {{(MAX_DIGITS-4){4'hF}}, 16'h1234};

  typedef enum logic [3:0] {
    S_IDLE, S_AUTH, S_BIP_EN, S_BIP_TIME, S_TRC_TIME, S_MASTER, S_USER, S_SAVE, S_ABORT
  } state_t;

  // digits_valid is a one-cycle strobe with no ready: every strobe is consumed on the edge it
  // is sampled, and a packet that is not accepted simply leaves the menu where it was.
  state_t          state_q, state_d, adv_state;
  logic [IW-1:0]   idx_q, idx_d, adv_idx;
  logic [FW-1:0]   fails_q, fails_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            sh_bip_q, sh_bip_d;
  logic [6:0]      sh_bt_q, sh_bt_d, sh_tt_q, sh_tt_d;
  logic [PW-1:0]   sh_master_q, sh_master_d;
  logic [UW-1:0]   sh_user_q, sh_user_d;

  logic            c_bip_q, c_bip_d;
  logic [6:0]      c_bt_q, c_bt_d, c_tt_q, c_tt_d;
  logic [PW-1:0]   c_master_q, c_master_d;
  logic [UW-1:0]   c_user_q, c_user_d;

  logic            ok_q, ok_d, abort_q, abort_d;
  logic            disp_en_q, disp_en_d;
  logic [23:0]     bcd_q, bcd_d;

  logic [3:0]      d0, d1;
  logic            is_skip, is_save, time_ok, pwd_ok, accept;
  logic [6:0]      tens_v, time_raw, time_val;

  assign d0      = digits_value[3:0];
  assign d1      = digits_value[7:4];
  assign is_skip = (digits_value == {MAX_DIGITS{4'hF}});
  assign is_save = (digits_value == {MAX_DIGITS{4'hB}});
  assign time_ok = (d0 <= 4'd9) && ((d1 <= 4'd9) || (d1 == 4'hF));
  assign tens_v  = (d1 == 4'hF) ? 7'd0 : {3'b000, d1};
  assign time_raw = tens_v * 7'd10 + {3'b000, d0};

  always_comb begin
    time_val = time_raw;
    if (time_raw < 7'(T_MIN))      time_val = 7'(T_MIN);
    else if (time_raw > 7'(T_MAX)) time_val = 7'(T_MAX);
  end

  always_comb begin
    pwd_ok = 1'b1;
    for (int i = 0; i < MIN_PWD_DIGITS; i++)
      if (digits_value[4*i +: 4] > 4'd9) pwd_ok = 1'b0;
  end

  always_comb begin
    adv_state = state_q;
    adv_idx   = idx_q;
    case (state_q)
      S_BIP_EN:   adv_state = S_BIP_TIME;
      S_BIP_TIME: adv_state = S_TRC_TIME;
      S_TRC_TIME: adv_state = S_MASTER;
      S_MASTER: begin
        adv_state = S_USER;
        adv_idx   = '0;
      end
      S_USER: begin
        if (idx_q == IW'(N_USERS - 1)) adv_state = S_SAVE;
        else                           adv_idx   = idx_q + IW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fails_d     = fails_q;
    timer_d     = timer_q;
    accept      = 1'b0;
    sh_bip_d    = sh_bip_q;
    sh_bt_d     = sh_bt_q;
    sh_tt_d     = sh_tt_q;
    sh_master_d = sh_master_q;
    sh_user_d   = sh_user_q;
    c_bip_d     = c_bip_q;
    c_bt_d      = c_bt_q;
    c_tt_d      = c_tt_q;
    c_master_d  = c_master_q;
    c_user_d    = c_user_q;
    ok_d        = 1'b0;
    abort_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup_on) begin
          state_d     = S_AUTH;
          idx_d       = '0;
          fails_d     = '0;
          timer_d     = '0;
          sh_bip_d    = c_bip_q;
          sh_bt_d     = c_bt_q;
          sh_tt_d     = c_tt_q;
          sh_master_d = c_master_q;
          sh_user_d   = c_user_q;
        end
      end
      S_SAVE: begin
        c_bip_d    = sh_bip_q;
        c_bt_d     = sh_bt_q;
        c_tt_d     = sh_tt_q;
        c_master_d = sh_master_q;
        c_user_d   = sh_user_q;
        ok_d       = 1'b1;
        state_d    = S_IDLE;
      end
      S_ABORT: begin
        abort_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = timer_q + TW'(1);
        if (digits_valid) begin
          timer_d = '0;
          if (state_q == S_AUTH) begin
            if (digits_value == c_master_q) begin
              state_d = S_BIP_EN;
            end else begin
              fails_d = fails_q + FW'(1);
              if (fails_q == FW'(MAX_AUTH_TRIES - 1)) state_d = S_ABORT;
            end
          end else if (is_save) begin
            state_d = S_SAVE;
          end else if (is_skip) begin
            accept = 1'b1;
          end else begin
            case (state_q)
              S_BIP_EN: if (d0 <= 4'd1) begin
                sh_bip_d = d0[0];
                accept   = 1'b1;
              end
              S_BIP_TIME: if (time_ok) begin
                sh_bt_d = time_val;
                accept  = 1'b1;
              end
              S_TRC_TIME: if (time_ok) begin
                sh_tt_d = time_val;
                accept  = 1'b1;
              end
              S_MASTER: if (pwd_ok) begin
                sh_master_d = digits_value;
                accept      = 1'b1;
              end
              S_USER: if (pwd_ok) begin
                sh_user_d[int'(idx_q)*PW +: PW] = digits_value;
                accept                          = 1'b1;
              end
              default: ;
            endcase
          end
          if (accept) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_ABORT;
        end
      end
    endcase
  end

  function automatic logic [7:0] to_bcd2(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // The display follows the state being entered so it updates on the same edge as the menu.
  always_comb begin
    bcd_d     = {6{4'hF}};
    disp_en_d = (state_d != S_IDLE);
    case (state_d)
      S_AUTH:     bcd_d[23:20] = 4'h0;
      S_BIP_EN: begin
        bcd_d[23:20] = 4'h1;
        bcd_d[3:0]   = {3'b000, sh_bip_d};
      end
      S_BIP_TIME: begin
        bcd_d[23:20] = 4'h2;
        bcd_d[7:0]   = to_bcd2(sh_bt_d);
      end
      S_TRC_TIME: begin
        bcd_d[23:20] = 4'h3;
        bcd_d[7:0]   = to_bcd2(sh_tt_d);
      end
      S_MASTER:   bcd_d[23:20] = 4'h4;
      S_USER:     bcd_d[23:20] = 4'd5 + {1'b0, idx_d};
      S_SAVE:     bcd_d[23:20] = 4'hA;
      S_ABORT:    bcd_d[23:20] = 4'hE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fails_q     <= '0;
      timer_q     <= '0;
      sh_bip_q    <= 1'b1;
      sh_bt_q     <= 7'(T_MIN);
      sh_tt_q     <= 7'(T_MIN);
      sh_master_q <= MASTER_RST;
      sh_user_q   <= '1;
      c_bip_q     <= 1'b1;
      c_bt_q      <= 7'd5;
      c_tt_q      <= 7'd5;
      c_master_q  <= MASTER_RST;
      c_user_q    <= '1;
      ok_q        <= 1'b0;
      abort_q     <= 1'b0;
      disp_en_q   <= 1'b0;
      bcd_q       <= {6{4'hF}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fails_q     <= fails_d;
      timer_q     <= timer_d;
      sh_bip_q    <= sh_bip_d;
      sh_bt_q     <= sh_bt_d;
      sh_tt_q     <= sh_tt_d;
      sh_master_q <= sh_master_d;
      sh_user_q   <= sh_user_d;
      c_bip_q     <= c_bip_d;
      c_bt_q      <= c_bt_d;
      c_tt_q      <= c_tt_d;
      c_master_q  <= c_master_d;
      c_user_q    <= c_user_d;
      ok_q        <= ok_d;
      abort_q     <= abort_d;
      disp_en_q   <= disp_en_d;
      bcd_q       <= bcd_d;
    end
  end

  assign display_en       = disp_en_q;
  assign bcd              = bcd_q;
  assign cfg_bip_status   = c_bip_q;
  assign cfg_bip_time     = c_bt_q;
  assign cfg_trc_time     = c_tt_q;
  assign cfg_senha_master = c_master_q;
  assign cfg_senha_user   = c_user_q;
  assign cfg_ok           = ok_q;
  assign cfg_abort        = abort_q;

endmodule

// File: tb/tb_setup_menu.sv
// Randomised and directed bench for setup_menu; a menu-position model predicts the display
// after every strobe and the committed configuration at every cfg_ok / cfg_abort pulse.
module tb_setup_menu;
  parameter int N_USERS = 4;
  localparam int MAX_DIGITS = 20;
  localparam int MIN_PWD    = 4;
  localparam int T_MIN      = 5;
  localparam int T_MAX      = 60;
  localparam int TRIES      = 3;
  localparam int TO         = 100;
  localparam int PW         = 4 * MAX_DIGITS;
  localparam int UW         = N_USERS * PW;
  localparam int W          = 16 + PW + UW;
  localparam int P_SAVE     = 100;
  localparam int P_ABORT    = 101;
  localparam logic [PW-1:0] SKIP_PKT = '1;
  localparam logic [PW-1:0] SAVE_PKT = {MAX_DIGITS{4'hB}};

  logic            clk = 1'b0;
  logic            rst, setup_on, digits_valid;
  logic [PW-1:0]   digits_value;
  logic            display_en, cfg_bip_status, cfg_ok, cfg_abort;
  logic [23:0]     bcd;
  logic [6:0]      cfg_bip_time, cfg_trc_time;
  logic [PW-1:0]   cfg_senha_master;
  logic [UW-1:0]   cfg_senha_user;

  setup_menu #(
    .N_USERS(N_USERS), .MAX_DIGITS(MAX_DIGITS), .MIN_PWD_DIGITS(MIN_PWD),
    .T_MIN(T_MIN), .T_MAX(T_MAX), .MAX_AUTH_TRIES(TRIES), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .setup_on(setup_on), .digits_value(digits_value),
    .digits_valid(digits_valid), .display_en(display_en), .bcd(bcd),
    .cfg_bip_status(cfg_bip_status), .cfg_bip_time(cfg_bip_time),
    .cfg_trc_time(cfg_trc_time), .cfg_senha_master(cfg_senha_master),
    .cfg_senha_user(cfg_senha_user), .cfg_ok(cfg_ok), .cfg_abort(cfg_abort)
  );

  always #5 clk = ~clk;

  logic [W-1:0]  exp_q[$];
  logic [24:0]   disp_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          strobe_seen = 1'b0;

  // reference model: committed (m_) and shadow (s_) settings plus menu position
  logic          m_bip, s_bip;
  int            m_bt, m_tt, s_bt, s_tt;
  logic [PW-1:0] m_master, s_master;
  logic [PW-1:0] m_users [N_USERS];
  logic [PW-1:0] s_users [N_USERS];
  int            pos, fails;
  bit            in_session;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] cfg_word(input logic kind);
    logic [UW-1:0] u;
    for (int i = 0; i < N_USERS; i++) u[i*PW +: PW] = m_users[i];
    return {kind, m_bip, 7'(m_bt), 7'(m_tt), m_master, u};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {cfg_abort, cfg_bip_status, cfg_bip_time, cfg_trc_time, cfg_senha_master, cfg_senha_user};
  endfunction

  function automatic logic [24:0] disp_word();
    logic [3:0] d[6];
    for (int i = 0; i < 6; i++) d[i] = 4'hF;
    if (pos == P_SAVE)       d[5] = 4'hA;
    else if (pos == P_ABORT) d[5] = 4'hE;
    else begin
      d[5] = 4'(pos);
      if (pos == 1) d[0] = {3'b000, s_bip};
      if (pos == 2) begin d[1] = 4'(s_bt / 10); d[0] = 4'(s_bt % 10); end
      if (pos == 3) begin d[1] = 4'(s_tt / 10); d[0] = 4'(s_tt % 10); end
    end
    return {1'b1, d[5], d[4], d[3], d[2], d[1], d[0]};
  endfunction

  function automatic logic [3:0] dig(input logic [PW-1:0] p, input int i);
    return p[4*i +: 4];
  endfunction

  function automatic logic [PW-1:0] num_pkt(input logic [31:0] hex, input int len);
    logic [PW-1:0] p;
    p = '1;
    for (int i = 0; i < len; i++) p[4*i +: 4] = hex[4*i +: 4];
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_num(input int len, input int maxd);
    logic [PW-1:0] p;
    p = '1;
    for (int i = 0; i < len; i++) p[4*i +: 4] = 4'($urandom_range(0, maxd));
    return p;
  endfunction

  task automatic model_reset();
    m_bip = 1'b1; m_bt = 5; m_tt = 5;
    m_master = '1; m_master[15:0] = 16'h1234;
    for (int i = 0; i < N_USERS; i++) m_users[i] = '1;
    pos = 0; fails = 0; in_session = 0;
  endtask

  task automatic commit();
    m_bip = s_bip; m_bt = s_bt; m_tt = s_tt; m_master = s_master;
    for (int i = 0; i < N_USERS; i++) m_users[i] = s_users[i];
    pos = P_SAVE;
    exp_q.push_back(cfg_word(1'b0));
  endtask

  task automatic advance();
    pos++;
    if (pos == 5 + N_USERS) commit();
  endtask

  task automatic model_step(input logic [PW-1:0] p);
    logic [3:0] d0, d1;
    int v;
    bit ok;
    d0 = dig(p, 0);
    d1 = dig(p, 1);
    if (pos == 0) begin
      if (p == m_master) pos = 1;
      else begin
        fails++;
        if (fails == TRIES) begin pos = P_ABORT; exp_q.push_back(cfg_word(1'b1)); end
      end
    end else if (p == SAVE_PKT) commit();
    else if (p == SKIP_PKT) advance();
    else if (pos == 1) begin
      if (d0 <= 1) begin s_bip = d0[0]; advance(); end
    end else if (pos == 2 || pos == 3) begin
      if (d0 <= 9 && (d1 <= 9 || d1 == 4'hF)) begin
        v = ((d1 == 4'hF) ? 0 : int'(d1)) * 10 + int'(d0);
        if (v < T_MIN) v = T_MIN;
        if (v > T_MAX) v = T_MAX;
        if (pos == 2) s_bt = v; else s_tt = v;
        advance();
      end
    end else begin
      ok = 1;
      for (int i = 0; i < MIN_PWD; i++) if (dig(p, i) > 9) ok = 0;
      if (ok) begin
        if (pos == 4) s_master = p; else s_users[pos-5] = p;
        advance();
      end
    end
    if (pos >= P_SAVE) in_session = 0;
  endtask

  // driver tasks: each starts and ends 1 ns after a rising edge
  task automatic send(input logic [PW-1:0] p);
    model_step(p);
    disp_q.push_back(disp_word());
    digits_value = p;
    digits_valid = 1'b1;
    @(posedge clk); #1;
    digits_valid = 1'b0;
    digits_value = SKIP_PKT;
  endtask

  task automatic start_session();
    s_bip = m_bip; s_bt = m_bt; s_tt = m_tt; s_master = m_master;
    for (int i = 0; i < N_USERS; i++) s_users[i] = m_users[i];
    pos = 0; fails = 0; in_session = 1;
    setup_on = 1'b1;
    @(posedge clk); #1;
    setup_on = 1'b0;
  endtask

  task automatic idle(input int k);
    if (in_session && k >= TO) begin
      pos = P_ABORT; in_session = 0;
      exp_q.push_back(cfg_word(1'b1));
    end
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset(input string name);
    @(negedge clk);
    check({name, "_disp"}, W'({display_en, bcd}), W'({1'b0, 24'hFFFFFF}));
    check({name, "_pulses"}, W'({cfg_ok, cfg_abort}), '0);
    check({name, "_cfg"}, dut_word(), cfg_word(1'b0));
    @(posedge clk); #1;
  endtask

  function automatic logic [PW-1:0] gen_pkt();
    int r;
    logic [PW-1:0] p;
    r = $urandom_range(0, 9);
    if (pos == 0) return (r < 8) ? m_master : rand_num($urandom_range(1, 8), 9);
    if (r == 0) return SKIP_PKT;
    if (r == 9) return SAVE_PKT;
    if (pos == 1) return rand_num(1, 2);
    if (pos == 2 || pos == 3) begin
      p = rand_num(2, 10);
      if ($urandom_range(0, 2) == 0) p[7:4] = 4'hF;
      return p;
    end
    return rand_num($urandom_range(2, 8), 9);
  endfunction

  // monitor: display after every strobe, configuration at every commit/discard pulse
  always @(posedge clk) strobe_seen <= digits_valid;

  always @(negedge clk) begin
    if (!rst) begin
      if (strobe_seen) begin
        if (disp_q.size() == 0) begin
          n_checks++;
          $display("FAIL disp_unexpected: got %0h expected nothing", {display_en, bcd});
        end else check("disp", W'({display_en, bcd}), W'(disp_q.pop_front()));
      end
      if (cfg_ok || cfg_abort) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL cfg_unexpected: got ok=%0b abort=%0b expected no pulse", cfg_ok, cfg_abort);
        end else check("cfg_event", dut_word(), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; setup_on = 1'b0; digits_valid = 1'b0; digits_value = SKIP_PKT;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset("reset");

    // enter with factory master, save immediately
    start_session();
    send(num_pkt(32'h1234, 4));
    send(SAVE_PKT);
    idle(4);

    // three wrong master entries abort the session
    start_session();
    for (int i = 0; i < TRIES; i++) send(num_pkt(32'h9990 + 32'(i), 4));
    idle(4);

    // full pass with ignored packets and clamped times
    start_session();
    send(num_pkt(32'h1234, 4));
    send(num_pkt(32'h7, 1));
    send(num_pkt(32'h0, 1));
    send(num_pkt(32'h3, 1));
    send(num_pkt(32'h75, 2));
    send(num_pkt(32'h123, 3));
    send(num_pkt(32'h5678, 4));
    for (int u = 0; u < N_USERS; u++) send(num_pkt(32'h1111 * 32'(u + 1), 4));
    idle(4);

    // inactivity: a late strobe keeps the session alive, a full timeout discards edits
    start_session();
    send(m_master);
    send(num_pkt(32'h1, 1));
    idle(TO - 2);
    send(num_pkt(32'h12, 2));
    idle(TO);
    idle(4);
    start_session();
    send(m_master);
    send(SAVE_PKT);
    idle(4);

    for (int s = 0; s < 12; s++) begin
      start_session();
      for (int n = 0; in_session && n < 60; n++) begin
        if (n > 30 && pos > 0) send(SAVE_PKT);
        else send(gen_pkt());
        idle($urandom_range(0, 3));
      end
      idle(4);
    end

    // reset mid-session restores factory configuration
    start_session();
    send(m_master);
    send(num_pkt(32'h0, 1));
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_reset("midrst");
    start_session();
    send(num_pkt(32'h1234, 4));
    send(SAVE_PKT);
    idle(6);

    check("final_cfg", dut_word(), cfg_word(1'b0));
    check("exp_q_drained", W'(exp_q.size()), '0);
    check("disp_q_drained", W'(disp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/setup_menu.md
# setup_menu

Parametrised configuration-menu controller for the electronic lock. It authenticates the master password, then steps the keypad user through beep enable, beep time, auto-lock time, the master password and N_USERS user passwords. All edits go to a shadow copy that is committed atomically on save, or discarded on abort, wrong-password lockout or inactivity timeout. It sits between the keypad digit collector and the lock core/display driver.

## Interface
- N_USERS, 4, number of user passwords, 1..5 (menu index 5..N_USERS+4 must fit one BCD digit)
- MAX_DIGITS, 20, digits per password packet
- MIN_PWD_DIGITS, 4, minimum password length accepted
- T_MIN, 5 / T_MAX, 60, clamp limits for both times (seconds)
- MAX_AUTH_TRIES, 3, wrong master entries before abort
- TIMEOUT_CYC, 100, idle cycles before abort
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- setup_on  in  1  request to enter setup, sampled only in IDLE
- digits_value  in  4*MAX_DIGITS  packet; digit[0] = bits[3:0] = last key; 4'hF = empty
- digits_valid  in  1  one-cycle strobe qualifying digits_value
- display_en  out  1  display owned by this block
- bcd  out  24  BCD5..BCD0, BCD5 = bits[23:20]
- cfg_bip_status  out  1  committed beep enable
- cfg_bip_time, cfg_trc_time  out  7  committed times
- cfg_senha_master  out  4*MAX_DIGITS  committed master password
- cfg_senha_user  out  N_USERS*4*MAX_DIGITS  user u at slice u
- cfg_ok  out  1  one-cycle pulse: new config committed
- cfg_abort  out  1  one-cycle pulse: session discarded

## Operation
- Codes: SKIP = all digits 4'hF (keep field, advance); SAVE = all digits 4'hB (jump to SAVE from any menu state, not AUTH).
- States: IDLE, AUTH, BIP_EN, BIP_TIME, TRC_TIME, MASTER, USER, SAVE, ABORT. USER iterates idx 0..N_USERS-1; after last → SAVE.
- IDLE: display_en=0. setup_on=1 → AUTH; shadow <= committed, fail count <= 0, timer reloaded.
- AUTH: exact 4*MAX_DIGITS compare with committed master. Match → BIP_EN. Mismatch → count+1; count reaching MAX_AUTH_TRIES → ABORT.
- BIP_EN: d0 ∈ {0,1} → shadow bit, advance; other non-code value ignored (stay).
- BIP_TIME/TRC_TIME: d0 must be 0..9, d1 0..9 or F (F = 0), else ignored; v = d1*10+d0 clamped to [T_MIN,T_MAX], stored, advance.
- MASTER/USER: accepted when digits[MIN_PWD_DIGITS-1:0] all 0..9; whole packet stored to shadow; else ignored.
- SAVE (1 cycle): committed <= shadow → IDLE. ABORT (1 cycle): shadow dropped → IDLE.
- Display (display_en=1 outside IDLE): BCD5 = 0 AUTH, 1 BIP_EN, 2 BIP_TIME, 3 TRC_TIME, 4 MASTER, 5+idx USER; BCD0 = shadow bip status (BIP_EN) or BCD1:BCD0 = shadow time tens:units; SAVE/ABORT: BCD5 = 4'hA/4'hE; other digits 4'hF.
- setup_on deassertion mid-session has no effect.

## Timing
- Reset: state IDLE, display_en 0, bcd all F, cfg_ok/cfg_abort 0, bip_status 1, both times 5, master = digits 3..0 = 1,2,3,4 rest F, users all F.
- One accepted packet = one state transition at the strobe edge; no back-pressure.
- cfg_* change only on the SAVE→IDLE edge; cfg_ok high the following cycle together with new values. cfg_abort high the cycle after ABORT.
- Timer reloads on every digits_valid and on entry to AUTH; reaching TIMEOUT_CYC in any state but IDLE/SAVE/ABORT → ABORT. Strobe and expiry same cycle: strobe wins.
- rst mid-session: everything, including committed config, returns to reset values.

## Test plan
- Reset, setup_on, enter ...F1234 → BIP_EN, BCD5=1; SAVE code → cfg_ok one cycle, config unchanged.
- Full pass: bip 0, time 3, trc 75, master ...5678, users 1111..4444 → cfg_bip_status 0, bip_time 5, trc_time 60, values on cfg_ok.
- Three wrong master packets → cfg_abort; cfg unchanged; new session requires ...1234.
- Bip value 7, password ...F123 → ignored, state and display unchanged.
- Edits then TIMEOUT_CYC idle → cfg_abort, edits discarded; strobe at cycle TIMEOUT_CYC-1 prevents abort.
- N_USERS=1 parameter run: MASTER → USER idx0 → SAVE; BCD5 = 5 in USER.
